// File: rtl/irq_responder.sv
// Interrupt responder: synchronizes and glitch-filters an external interrupt line,
// latches rising edges as a pending request and tracks the handler lifetime.
module irq_responder #(
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_irq_in,
   input  logic             i_ie,
   input  logic             i_irq_ack,
   input  logic             i_eret,
   output logic             o_irq_req,
   output logic             o_in_service,
   output logic             o_pending,
   output logic [CNT_W-1:0] o_irq_count,
   output logic [7:0]       o_lost_count
);

   localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   logic             r_s1;
   logic             r_s2;
   logic             r_filt;
   logic [FW-1:0]    r_fcnt;
   logic             r_deferred;
   logic [CNT_W-1:0] r_irq_count;
   logic [7:0]       r_lost_count;
   state_e           r_state;

   logic   w_filt_hit;
   logic   w_rise;
   state_e w_state_next;
   logic   w_deferred_next;
   logic   w_accept;
   logic   w_lost_inc;

   // Count reaching FILTER_CYCLES on this edge commits the new level.
   assign w_filt_hit = (r_s2 != r_filt) && (r_fcnt == FILT_LAST);
   assign w_rise     = w_filt_hit && r_s2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_filt <= 1'b0;
         r_fcnt <= '0;
      end else begin
         r_s1 <= i_irq_in;
         r_s2 <= r_s1;
         if (r_s2 != r_filt) begin
            if (w_filt_hit) begin
               r_filt <= r_s2;
               r_fcnt <= '0;
            end else begin
               r_fcnt <= r_fcnt + FW'(1);
            end
         end else begin
            r_fcnt <= '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_deferred <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_deferred <= w_deferred_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_deferred_next = r_deferred;
      w_accept        = 1'b0;
      w_lost_inc      = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_rise) w_state_next = StReq;
         end
         StReq: begin
            if (i_irq_ack && i_ie) begin
               w_state_next    = StService;
               w_accept        = 1'b1;
               w_deferred_next = w_rise;
            end else if (w_rise) begin
               w_lost_inc = 1'b1;
            end
         end
         StService: begin
            if (w_rise) begin
               if (r_deferred) w_lost_inc = 1'b1;
               else            w_deferred_next = 1'b1;
            end
            if (i_eret) begin
               w_state_next    = (r_deferred || w_rise) ? StReq : StIdle;
               w_deferred_next = 1'b0;
            end
         end
         default: begin
            w_state_next    = StIdle;
            w_deferred_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_irq_count  <= '0;
         r_lost_count <= '0;
      end else begin
         if (w_accept) r_irq_count <= r_irq_count + CNT_W'(1);
         if (w_lost_inc && (r_lost_count != 8'hFF)) r_lost_count <= r_lost_count + 8'd1;
      end
   end

   always_comb begin
      o_pending    = (r_state == StReq);
      o_in_service = (r_state == StService);
      o_irq_req    = o_pending && i_ie;
      o_irq_count  = r_irq_count;
      o_lost_count = r_lost_count;
   end

endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: a per-cycle vector table for the basic flow plus
// hand-written sequences for glitch, deferral, gating, simultaneity and reset cases.
module tb_irq_responder;

   logic        clk;
   logic        reset;
   logic        irq_in;
   logic        ie;
   logic        irq_ack;
   logic        eret;
   logic        irq_req;
   logic        in_service;
   logic        pending;
   logic [15:0] irq_count;
   logic [7:0]  lost_count;

   int n_vec = 0;
   int n_bad = 0;

   irq_responder #(
      .FILTER_CYCLES(4),
      .CNT_W        (16)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_irq_in    (irq_in),
      .i_ie        (ie),
      .i_irq_ack   (irq_ack),
      .i_eret      (eret),
      .o_irq_req   (irq_req),
      .o_in_service(in_service),
      .o_pending   (pending),
      .o_irq_count (irq_count),
      .o_lost_count(lost_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        irq;
      logic        ie;
      logic        ack;
      logic        eret;
      logic        req;
      logic        svc;
      logic        pend;
      logic [15:0] cnt;
      logic [7:0]  lost;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic i_irq, input logic i_ack, input logic i_eret,
                               input logic e_req, input logic e_svc, input logic e_pend,
                               input logic [15:0] e_cnt);
      vec_t v;
      v.irq  = i_irq;
      v.ie   = 1'b1;
      v.ack  = i_ack;
      v.eret = i_eret;
      v.req  = e_req;
      v.svc  = e_svc;
      v.pend = e_pend;
      v.cnt  = e_cnt;
      v.lost = 8'd0;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic e_req, input logic e_svc,
                      input logic e_pend, input logic [15:0] e_cnt, input logic [7:0] e_lost);
      n_vec++;
      if (irq_req !== e_req || in_service !== e_svc || pending !== e_pend ||
          irq_count !== e_cnt || lost_count !== e_lost) begin
         n_bad++;
         $display("FAIL %s: got req=%b svc=%b pend=%b cnt=%0d lost=%0d, want req=%b svc=%b pend=%b cnt=%0d lost=%0d",
                  name, irq_req, in_service, pending, irq_count, lost_count,
                  e_req, e_svc, e_pend, e_cnt, e_lost);
      end
   endtask

   task automatic do_reset(input logic irq_level);
      reset   = 1'b1;
      irq_in  = irq_level;
      irq_ack = 1'b0;
      eret    = 1'b0;
      step();
      chk("reset", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
      reset = 1'b0;
   endtask

   task automatic hold(input logic level, input int cycles);
      irq_in = level;
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      reset = 1'b1; irq_in = 1'b0; ie = 1'b1; irq_ack = 1'b0; eret = 1'b0;
      step();

      // Basic flow: filt/pending land on the 6th edge after irq_in rises.
      vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[3] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[5] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
      vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
      vecs[7] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
      vecs[8] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
      for (int i = 9; i < 16; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

      do_reset(1'b0);
      for (int i = 0; i < 16; i++) begin
         irq_in  = vecs[i].irq;
         ie      = vecs[i].ie;
         irq_ack = vecs[i].ack;
         eret    = vecs[i].eret;
         step();
         chk($sformatf("basic[%0d]", i), vecs[i].req, vecs[i].svc, vecs[i].pend,
             vecs[i].cnt, vecs[i].lost);
      end
      irq_ack = 1'b0; eret = 1'b0;

      // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted.
      do_reset(1'b0);
      hold(1'b1, 3);
      hold(1'b0, 10);
      chk("glitch3", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
      hold(1'b1, 4);
      hold(1'b0, 1);
      chk("pulse4_early", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
      step();
      chk("pulse4", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0);

      // Deferral: two edges during service, one deferred and one lost.
      do_reset(1'b0);
      hold(1'b1, 8);
      chk("defer_req", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0);
      irq_in = 1'b0; irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("defer_ack", 1'b0, 1'b1, 1'b0, 16'd1, 8'd0);
      hold(1'b0, 8);
      hold(1'b1, 8);
      hold(1'b0, 8);
      chk("defer_first", 1'b0, 1'b1, 1'b0, 16'd1, 8'd0);
      hold(1'b1, 8);
      hold(1'b0, 8);
      chk("defer_second", 1'b0, 1'b1, 1'b0, 16'd1, 8'd1);
      eret = 1'b1;
      step();
      eret = 1'b0;
      chk("defer_eret", 1'b1, 1'b0, 1'b1, 16'd1, 8'd1);

      // Enable gating: pending held, spurious ack ignored, ie re-asserts combinationally.
      do_reset(1'b0);
      ie = 1'b0;
      hold(1'b1, 8);
      chk("gate_pend", 1'b0, 1'b0, 1'b1, 16'd0, 8'd0);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("gate_ack", 1'b0, 1'b0, 1'b1, 16'd0, 8'd0);
      ie = 1'b1;
      #1;
      chk("gate_ie", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0);

      // Simultaneous rise + accepted ack: deferred without a lost count.
      do_reset(1'b0);
      hold(1'b1, 8);
      hold(1'b0, 8);
      chk("sim_req", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0);
      hold(1'b1, 5);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("sim_ack", 1'b0, 1'b1, 1'b0, 16'd1, 8'd0);
      hold(1'b0, 3);
      eret = 1'b1;
      step();
      eret = 1'b0;
      chk("sim_eret", 1'b1, 1'b0, 1'b1, 16'd1, 8'd0);

      // Lost-edge saturation in REQ.
      do_reset(1'b0);
      hold(1'b1, 8);
      hold(1'b0, 8);
      for (int i = 1; i <= 260; i++) begin
         hold(1'b1, 8);
         hold(1'b0, 8);
         if (i == 1 || i == 255 || i == 260)
            chk($sformatf("lost[%0d]", i), 1'b1, 1'b0, 1'b1, 16'd0, (i > 255) ? 8'd255 : 8'(i));
      end

      // Reset mid-service with irq_in held high: re-detected as a new edge.
      do_reset(1'b0);
      hold(1'b1, 8);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("rst_svc", 1'b0, 1'b1, 1'b0, 16'd1, 8'd0);
      do_reset(1'b1);
      hold(1'b1, 5);
      chk("rst_edge5", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
      step();
      chk("rst_edge6", 1'b1, 1'b0, 1'b1, 16'd0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_responder.md
# irq_responder

Interrupt-response block inside `SoC`, between the external `interrupt` pin and the core's exception logic. Synchronizes and glitch-filters the asynchronous interrupt line, converts filtered rising edges into a latched pending request, holds `irq_req` to the core until accepted, and blocks further requests until the handler returns via `eret`. Keeps an accepted-interrupt count and a saturating lost-edge count for debug and LED display.

## Interface
- `FILTER_CYCLES`, default 4: consecutive synchronized samples needed to accept a level change; legal range is 1 or more.
- `CNT_W`, default 16: width of `irq_count`.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  1  raw external interrupt, asynchronous, active high.
- `ie`  in  1  global interrupt enable (CP0 Status.IE).
- `irq_ack`  in  1  one-cycle pulse: core has taken the interrupt exception.
- `eret`  in  1  one-cycle pulse: core executed `eret`.
- `irq_req`  out  1  interrupt request to the core.
- `in_service`  out  1  handler currently active.
- `pending`  out  1  edge latched, not yet accepted.
- `irq_count`  out  CNT_W  accepted interrupts; wraps around.
- `lost_count`  out  8  edges merged into an already-set pending; saturates at 255.

## Operation
- **Synchronizer:** two flops, `s1` <= `irq_in`, then `s2` <= `s1`.
- **Filter:**
  - `filt` is the accepted level; counter width is $clog2(FILTER_CYCLES+1).
  - Each cycle `s2 != filt`: the counter increments.
  - Each cycle `s2 == filt`: the counter clears.
  - When the count reaches FILTER_CYCLES, `filt` <= `s2` and the counter clears.
  - Falling transitions are filtered the same way.
- **Edge:** `rise` is combinational and true in the cycle where `filt` is about to go from 0 to 1. It acts at that same clock edge.
- **States:** IDLE, REQ, SERVICE.
  - `pending` = (state == REQ).
  - `in_service` = (state == SERVICE).
  - `irq_req` = `pending` & `ie`.
- **Transitions:**
  - IDLE, `rise` -> REQ.
  - REQ, `irq_ack` & `ie` -> SERVICE; `irq_count` increments.
  - REQ, `rise` -> stay in REQ; `lost_count` increments (saturating).
  - SERVICE, `rise` -> set the internal flag `deferred`. If `deferred` was already 1, `lost_count` increments instead.
  - SERVICE, `eret` -> REQ if `deferred` or `rise`, else IDLE; `deferred` clears.
- **Ignored inputs:** `irq_ack` with `irq_req`=0; `eret` outside SERVICE.
- **Simultaneous events:**
  - `rise` + accepted `irq_ack` in REQ: go to SERVICE with `deferred`=1; `lost_count` unchanged.
  - `rise` + `eret` in SERVICE: go to REQ.
- **`ie`=0:** `pending` is held and `irq_req` stays low. Raising `ie` re-asserts `irq_req` in the same cycle.
- **Reset:**
  - Clears `s1`, `s2`, `filt`, the filter counter, `deferred`, both counts and the state (IDLE).
  - Reset mid-service abandons the handler.
  - If `irq_in` is high after reset, it is treated as a new rising edge, because `filt` restarts at 0.

## Timing
- **Reset values:** all outputs are 0.
- **Latency:**
  - `irq_in` is high before edge n and stays high.
  - `s2` is 1 after edge n+1.
  - `filt`, `pending` and `irq_req` (with `ie`=1) are 1 after edge n+1+FILTER_CYCLES. With the default, that is edge n+5.
- **Rejection:** a pulse whose `s2` stays high for fewer than FILTER_CYCLES consecutive cycles is rejected. A 1-3 cycle pulse never sets `pending` (default FILTER_CYCLES).
- **Re-trigger:** a new edge needs `filt` low first, which takes FILTER_CYCLES cycles low after sync.
- **`irq_ack`:** `irq_req` deasserts the cycle after `irq_ack` is sampled, and `in_service` rises in that same cycle.
- **`eret`:** `in_service` falls the cycle after `eret`. A deferred request re-asserts `irq_req` in that same cycle.
- **Counter updates:** both counts update on the accepting clock edge and are visible the next cycle.

## Test plan
- **Basic:** `ie`=1, `irq_in` 0->1 held 8 cycles. `irq_req`=1 exactly 5 edges after the first sampling edge. `irq_ack` pulse -> `irq_req`=0, `in_service`=1, `irq_count`=1. `eret` -> `in_service`=0, state IDLE.
- **Glitch:** 3-cycle `irq_in` pulse -> `pending` stays 0 and `irq_count`=0. 4-cycle pulse -> `pending`=1.
- **Deferral:** during SERVICE, two separate 8-cycle pulses (8 cycles low between them) -> `irq_req` stays 0 and `lost_count`=1. `eret` -> `irq_req`=1 in the next cycle.
- **Enable gating:** `ie`=0 with an edge -> `pending`=1, `irq_req`=0. A spurious `irq_ack` is ignored, so `irq_count`=0. Setting `ie`=1 -> `irq_req`=1 the same cycle.
- **Simultaneous:** `rise` on the same edge as an accepted `irq_ack` -> SERVICE with `deferred`; `lost_count` unchanged; after `eret`, `irq_req`=1. Separately, 260 merged edges in REQ -> `lost_count`=255.
- **Reset mid-service:** assert `reset` for 1 cycle while in SERVICE with `irq_in` held high -> all outputs 0 the next cycle, then `pending`=1 at reset release + FILTER_CYCLES+2 edges.
